// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller beside the M stage: SR, Cause, EPC, PRId,
// flush/redirect request and mfc0/mtc0/eret servicing.
module cp0_exc_ctrl #(
    parameter logic [31:0] PRID_VAL   = 32'h0000_2022,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A,
    input  logic        WE,
    input  logic [31:0] DIn,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        Req,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    localparam logic [4:0] A_SR    = 5'd12;
    localparam logic [4:0] A_CAUSE = 5'd13;
    localparam logic [4:0] A_EPC   = 5'd14;
    localparam logic [4:0] A_PRID  = 5'd15;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req, exc_req;
    logic [31:0] sr_word, cause_word;

    // Fetch consumes the handler address directly; it is kept here for reference.
    logic unused_handler;
    assign unused_handler = ^HANDLER_PC;

    assign int_req = ie_q & ~exl_q & (|(HWInt & im_q));
    assign exc_req = ~exl_q & (ExcCodeIn != 5'd0);
    assign Req     = int_req | exc_req;

    assign sr_word    = {16'b0, im_q, 8'b0, exl_q, ie_q};
    assign cause_word = {bd_q, 15'b0, ip_q, 3'b0, exc_q, 2'b0};

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        ip_d  = HWInt;
        exc_d = exc_q;
        epc_d = epc_q;

        // Exception entry wins over a coincident mtc0.
        if (Req) begin
            exl_d = 1'b1;
            bd_d  = BDIn;
            exc_d = int_req ? 5'd0 : ExcCodeIn;
            epc_d = BDIn ? (VPC - 32'd4) : VPC;
        end else if (WE) begin
            case (A)
                A_SR: begin
                    im_d  = DIn[15:10];
                    exl_d = DIn[1];
                    ie_d  = DIn[0];
                end
                A_EPC:   epc_d = DIn;
                default: ;
            endcase
        end

        if (EXLClr && !Req)
            exl_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            im_q  <= '0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= '0;
            exc_q <= '0;
            epc_q <= '0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= ip_d;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    assign EPCOut = epc_q;

    always_comb begin
        DOut = 32'd0;
        case (A)
            A_SR:    DOut = sr_word;
            A_CAUSE: DOut = cause_word;
            A_EPC:   DOut = epc_q;
            A_PRID:  DOut = PRID_VAL;
            default: DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios plus randomized traffic against a
// word-level CP0 model.
module tb_cp0_exc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A;
    logic        WE;
    logic [31:0] DIn;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic        Req;
    logic [31:0] EPCOut;
    logic [31:0] DOut;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_sr, m_cause, m_epc;

    cp0_exc_ctrl dut (
        .clk(clk), .reset(reset), .A(A), .WE(WE), .DIn(DIn), .VPC(VPC),
        .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt), .EXLClr(EXLClr),
        .Req(Req), .EPCOut(EPCOut), .DOut(DOut)
    );

    always #5 clk = ~clk;

    function automatic logic m_int();
        return m_sr[0] && !m_sr[1] && ((HWInt & m_sr[15:10]) != 6'd0);
    endfunction

    function automatic logic m_req();
        return m_int() || (!m_sr[1] && ExcCodeIn != 5'd0);
    endfunction

    function automatic logic [31:0] m_dout(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h0000_2022;
            default: return 32'd0;
        endcase
    endfunction

    // Advance one clock: model next state from current inputs, then edge.
    task automatic tick();
        logic [31:0] s, c, e;
        logic r;
        r = m_req();
        s = m_sr; c = m_cause; e = m_epc;
        c = (c & ~32'h0000_FC00) | ({26'd0, HWInt} << 10);
        if (r) begin
            s = s | 32'h2;
            c = (c & 32'h7FFF_FF83) | ({31'd0, BDIn} << 31)
                | ({27'd0, (m_int() ? 5'd0 : ExcCodeIn)} << 2);
            e = BDIn ? VPC - 32'd4 : VPC;
        end else if (WE) begin
            if (A == 5'd12) s = DIn & 32'h0000_FC03;
            if (A == 5'd14) e = DIn;
        end
        if (EXLClr && !r) s = s & ~32'h2;
        if (reset) begin s = 0; c = 0; e = 0; end
        @(posedge clk);
        m_sr = s; m_cause = c; m_epc = e;
        @(negedge clk);
    endtask

    task automatic idle();
        reset = 0; A = 5'd0; WE = 0; DIn = 0; VPC = 0; BDIn = 0;
        ExcCodeIn = 0; HWInt = 0; EXLClr = 0;
    endtask

    task automatic clear_exl();
        idle(); EXLClr = 1; tick(); idle();
    endtask

    task automatic test_reset();
        idle(); reset = 1; tick(); tick(); idle(); #1;
        checks++; if (Req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b want=0", Req); end
        checks++; if (EPCOut !== 32'd0) begin failures++; $display("FAIL reset_epcout got=%h want=0", EPCOut); end
        A = 5'd12; #1;
        checks++; if (DOut !== 32'd0) begin failures++; $display("FAIL reset_sr got=%h want=0", DOut); end
        A = 5'd13; #1;
        checks++; if (DOut !== 32'd0) begin failures++; $display("FAIL reset_cause got=%h want=0", DOut); end
    endtask

    task automatic test_int_entry();
        idle(); WE = 1; A = 5'd12; DIn = 32'h0000_0401; #1;
        checks++; if (Req !== 1'b0) begin failures++; $display("FAIL int_mtc0_req got=%0b want=0", Req); end
        tick();
        idle(); HWInt = 6'b000001; VPC = 32'h3010; #1;
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL int_req got=%0b want=1", Req); end
        tick();
        A = 5'd12; #1;
        checks++; if (DOut !== 32'h0000_0403) begin failures++; $display("FAIL int_sr got=%h want=00000403", DOut); end
        A = 5'd13; #1;
        checks++; if (DOut !== 32'h0000_0400) begin failures++; $display("FAIL int_cause got=%h want=00000400", DOut); end
        checks++; if (EPCOut !== 32'h3010) begin failures++; $display("FAIL int_epc got=%h want=00003010", EPCOut); end
        checks++; if (Req !== 1'b0) begin failures++; $display("FAIL int_req_after got=%0b want=0", Req); end
        clear_exl();
    endtask

    task automatic test_exc_bd();
        idle(); WE = 1; A = 5'd12; DIn = 32'd0; tick();
        idle(); ExcCodeIn = 5'd12; BDIn = 1; VPC = 32'h3024; #1;
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL exc_req got=%0b want=1", Req); end
        tick();
        idle(); A = 5'd13; #1;
        checks++; if (DOut !== 32'h8000_0030) begin failures++; $display("FAIL exc_cause got=%h want=80000030", DOut); end
        checks++; if (EPCOut !== 32'h3020) begin failures++; $display("FAIL exc_epc got=%h want=00003020", EPCOut); end
        clear_exl();
    endtask

    task automatic test_priority();
        idle(); WE = 1; A = 5'd12; DIn = 32'h0000_0401; tick();
        idle(); HWInt = 6'b000001; ExcCodeIn = 5'd4; VPC = 32'h3100; #1;
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL prio_req got=%0b want=1", Req); end
        tick();
        idle(); A = 5'd13; #1;
        checks++; if (DOut !== 32'h0000_0400) begin failures++; $display("FAIL prio_cause got=%h want=00000400", DOut); end
        checks++; if (EPCOut !== 32'h3100) begin failures++; $display("FAIL prio_epc got=%h want=00003100", EPCOut); end
        clear_exl();
    endtask

    task automatic test_exl_block();
        idle(); WE = 1; A = 5'd12; DIn = 32'h0000_0403; tick();
        idle(); ExcCodeIn = 5'd10; HWInt = 6'b000001; #1;
        checks++; if (Req !== 1'b0) begin failures++; $display("FAIL exl_block_req got=%0b want=0", Req); end
        tick();
        ExcCodeIn = 5'd0; EXLClr = 1; A = 5'd13; #1;
        checks++; if (DOut !== 32'h0000_0400) begin failures++; $display("FAIL exl_cause got=%h want=00000400", DOut); end
        checks++; if (Req !== 1'b0) begin failures++; $display("FAIL exl_clr_req got=%0b want=0", Req); end
        tick();
        EXLClr = 0; A = 5'd12; VPC = 32'h3200; #1;
        checks++; if (DOut !== 32'h0000_0401) begin failures++; $display("FAIL exl_sr_cleared got=%h want=00000401", DOut); end
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL exl_pending_req got=%0b want=1", Req); end
        tick();
        checks++; if (EPCOut !== 32'h3200) begin failures++; $display("FAIL exl_pending_epc got=%h want=00003200", EPCOut); end
        clear_exl();
    endtask

    task automatic test_write_conflict();
        idle(); ExcCodeIn = 5'd8; VPC = 32'h3300; WE = 1; A = 5'd14; DIn = 32'hDEAD_BEEF; #1;
        checks++; if (Req !== 1'b1) begin failures++; $display("FAIL wc_req got=%0b want=1", Req); end
        tick();
        idle(); #1;
        checks++; if (EPCOut !== 32'h3300) begin failures++; $display("FAIL wc_epc got=%h want=00003300", EPCOut); end
        A = 5'd15; #1;
        checks++; if (DOut !== 32'h0000_2022) begin failures++; $display("FAIL prid got=%h want=00002022", DOut); end
        A = 5'd7; #1;
        checks++; if (DOut !== 32'd0) begin failures++; $display("FAIL a7_read got=%h want=0", DOut); end
        clear_exl();
    endtask

    task automatic test_reset_in_exl();
        idle(); WE = 1; A = 5'd12; DIn = 32'h0000_FC03; tick();
        idle(); HWInt = 6'h3F; reset = 1; tick();
        reset = 0; A = 5'd12; #1;
        checks++; if (DOut !== 32'd0) begin failures++; $display("FAIL rst_exl_sr got=%h want=0", DOut); end
        A = 5'd13; #1;
        checks++; if (DOut !== 32'd0) begin failures++; $display("FAIL rst_exl_cause got=%h want=0", DOut); end
        checks++; if (EPCOut !== 32'd0) begin failures++; $display("FAIL rst_exl_epc got=%h want=0", EPCOut); end
        checks++; if (Req !== 1'b0) begin failures++; $display("FAIL rst_exl_req got=%0b want=0", Req); end
        idle();
    endtask

    task automatic test_random();
        logic [4:0] regs [5];
        regs = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
        for (int i = 0; i < 600; i++) begin
            reset     = ($urandom_range(0, 39) == 0);
            A         = ($urandom_range(0, 7) == 0) ? 5'($urandom) : regs[$urandom_range(0, 4)];
            WE        = ($urandom_range(0, 3) == 0);
            DIn       = ($urandom_range(0, 1) == 0) ? $urandom : ($urandom | 32'h1) & ~32'h2;
            VPC       = $urandom_range(0, 3) == 0 ? 32'd2 : $urandom;
            BDIn      = 1'($urandom);
            ExcCodeIn = ($urandom_range(0, 4) == 0) ? 5'($urandom) : 5'd0;
            HWInt     = 6'($urandom);
            EXLClr    = ($urandom_range(0, 5) == 0);
            #1;
            checks++; if (Req !== m_req()) begin failures++; $display("FAIL rnd_req cyc=%0d got=%0b want=%0b", i, Req, m_req()); end
            checks++; if (DOut !== m_dout(A)) begin failures++; $display("FAIL rnd_dout cyc=%0d A=%0d got=%h want=%h", i, A, DOut, m_dout(A)); end
            checks++; if (EPCOut !== m_epc) begin failures++; $display("FAIL rnd_epcout cyc=%0d got=%h want=%h", i, EPCOut, m_epc); end
            tick();
        end
        idle();
    endtask

    initial begin
        m_sr = 0; m_cause = 0; m_epc = 0;
        idle();
        test_reset();
        test_int_entry();
        test_exc_bd();
        test_priority();
        test_exl_block();
        test_write_conflict();
        test_reset_in_exl();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
